// File: rtl/branch_resolve_if.sv
// Bundle of the branch_resolve stage's upstream, comparator, downstream, redirect and BHT signals.
// The slave modport is the stage itself; the master modport is its surroundings.
interface branch_resolve_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            in_is_br;
  logic            in_is_jal;
  logic            in_is_jalr;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pred_pc;
  logic [2:0]      com_op;
  logic [XLEN-1:0] com_lhs;
  logic [XLEN-1:0] com_rhs;
  logic            com_res;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_link;
  logic            out_misalign;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] bht_pc;
  logic            bht_taken;

  modport slave (
    input  flush, in_valid, in_is_br, in_is_jal, in_is_jalr, in_funct3, in_pc, in_imm,
           in_rs1, in_rs2, in_pred_pc, com_res, out_ready, bht_pc,
    output in_ready, com_op, com_lhs, com_rhs, out_valid, out_taken, out_link, out_misalign,
           redirect_valid, redirect_pc, bht_taken
  );

  modport master (
    output flush, in_valid, in_is_br, in_is_jal, in_is_jalr, in_funct3, in_pc, in_imm,
           in_rs1, in_rs2, in_pred_pc, com_res, out_ready, bht_pc,
    input  in_ready, com_op, com_lhs, com_rhs, out_valid, out_taken, out_link, out_misalign,
           redirect_valid, redirect_pc, bht_taken
  );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution with a 1-entry valid/ready output slot and a
// one-cycle fetch redirect pulse on mispredict.
// Optional feature: define BRANCH_BHT_EN to add a table of 2-bit saturating counters
// that is looked up by bht_pc and trained by accepted conditional branches.
module branch_resolve #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64
) (
  input logic             clk,
  input logic             rst_n,
  branch_resolve_if.slave bus
);

  localparam int unsigned IdxW = $clog2(BHT_DEPTH);

  logic            out_valid_q;
  logic            out_taken_q;
  logic            out_misalign_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] out_link_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            accept;
  logic            is_ctrl;
  logic            taken;
  logic            misalign;
  logic            mispredict;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] next_pc;

  // Comparator operands are a pure pass-through, independent of in_valid.
  assign bus.com_op  = bus.in_funct3;
  assign bus.com_lhs = bus.in_rs1;
  assign bus.com_rhs = bus.in_rs2;

  assign bus.in_ready = !out_valid_q | bus.out_ready;
  // A flush squashes any same-cycle accept.
  assign accept       = bus.in_valid & bus.in_ready & !bus.flush;

  // Resolve the taken decision, target, link and mispredict for the incoming instruction.
  always_comb begin
    is_ctrl    = bus.in_is_br | bus.in_is_jal | bus.in_is_jalr;
    taken      = bus.in_is_jal | bus.in_is_jalr | (bus.in_is_br & bus.com_res);
    jalr_sum   = bus.in_rs1 + bus.in_imm;
    target     = bus.in_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (bus.in_pc + bus.in_imm);
    link       = bus.in_pc + XLEN'(4);
    next_pc    = taken ? target : link;
    misalign   = taken & (target[1:0] != 2'b00);
    // Non-control instructions never redirect, whatever fetch predicted.
    mispredict = is_ctrl & (next_pc != bus.in_pred_pc);
  end

  // Output slot: load on accept, drain on out_ready, cleared by flush; data holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_misalign_q   <= 1'b0;
      out_link_q       <= '0;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
    end else begin
      redirect_valid_q <= accept & mispredict;
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q    <= 1'b1;
        out_taken_q    <= taken;
        out_misalign_q <= misalign;
        out_link_q     <= link;
        redirect_pc_q  <= next_pc;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_taken      = out_taken_q;
  assign bus.out_misalign   = out_misalign_q;
  assign bus.out_link       = out_link_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

`ifdef BRANCH_BHT_EN
  logic [1:0]      bht_q [BHT_DEPTH];
  logic [IdxW-1:0] rd_idx;
  logic [IdxW-1:0] wr_idx;

  assign rd_idx = bus.bht_pc[IdxW+1:2];
  assign wr_idx = bus.in_pc[IdxW+1:2];
  // Reads come from the registered table, so a same-cycle update is not yet visible.
  assign bus.bht_taken = bht_q[rd_idx][1];

  // Train the counter of each accepted conditional branch, saturating at 00 and 11.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (accept && bus.in_is_br) begin
      if (taken && bht_q[wr_idx] != 2'b11) begin
        bht_q[wr_idx] <= bht_q[wr_idx] + 2'd1;
      end else if (!taken && bht_q[wr_idx] != 2'b00) begin
        bht_q[wr_idx] <= bht_q[wr_idx] - 2'd1;
      end
    end
  end
`else
  assign bus.bht_taken = 1'b0;
`endif

  // Bits of the lookup PC outside the index, and the unused depth in the default build.
  logic unused_bits;
  assign unused_bits = ^{bus.bht_pc, IdxW[0]};

endmodule
